serial_frame_receiver: RTL and testbench

- Downstream stage of the shift register.
- Consumes the serial bit stream on the shift register's `out` pin, delimits frames (start bit, WIDTH data bits, stop bit) and reassembles the parallel word.
- Presents each good word on a single-entry valid/ready output buffer.
- Reports framing errors and overruns as one-cycle pulses.

---
 rtl/serial_frame_pkg.sv | 6 +
 rtl/frame_out_buffer.sv | 40 ++++
 rtl/serial_frame_receiver.sv | 114 +++++++++++
 tb/tb_serial_frame_receiver.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: FSM state type and serial line levels for serial_frame_receiver.
package serial_frame_pkg;
    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} state_e;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
endpackage

// File: rtl/frame_out_buffer.sv
// frame_out_buffer: single-entry valid/ready holding register.
// It raises a one-cycle overrun pulse when a commit finds the entry full and not draining.
module frame_out_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit,
    input  logic [WIDTH-1:0] word,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             overrun
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d, overrun_q, overrun_d, load;

    always_comb begin
        load      = commit && (!valid_q || ready);
        data_d    = load ? word : data_q;
        valid_d   = load ? 1'b1 : (valid_q && ready) ? 1'b0 : valid_q;
        overrun_d = commit && valid_q && !ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign overrun  = overrun_q;
endmodule

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: deframes start / WIDTH data / stop bit frames into words on a valid/ready buffer.
// Define SERIAL_FRAME_RECEIVER_PARITY_EN to expect an even-parity bit between the data and stop bits.
module serial_frame_receiver
    import serial_frame_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic             direction,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
    localparam state_e AFTER_DATA = PARITY;
`else
    localparam state_e AFTER_DATA = STOP;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d, commit_q, commit_d, frame_err_q, frame_err_d, par_bad;

`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
    logic par_err_q, par_err_d;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par_err_q <= 1'b0;
        else      par_err_q <= par_err_d;
    end
    assign par_bad = par_err_q;
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        commit_d    = 1'b0;
        frame_err_d = 1'b0;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
        par_err_d   = par_err_q;
`endif
        if (en) begin
            case (state_q)
                IDLE: if (in == START_LEVEL) begin
                    state_d = DATA;
                    dir_d   = direction;
                    cnt_d   = '0;
                end
                DATA: begin
                    shift_d = dir_q ? {in, shift_q[WIDTH-1:1]} : {shift_q[WIDTH-2:0], in};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = AFTER_DATA;
                end
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
                PARITY: begin
                    par_err_d = ^{shift_q, in};
                    state_d   = STOP;
                end
`endif
                STOP: begin
                    commit_d    = (in == IDLE_LEVEL) && !par_bad;
                    frame_err_d = (in != IDLE_LEVEL) || par_bad;
                    state_d     = (in == IDLE_LEVEL) ? IDLE : BREAK;
                end
                // a held-low line must not be mistaken for fresh start bits
                BREAK: if (in == IDLE_LEVEL) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            commit_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            commit_q    <= commit_d;
            frame_err_q <= frame_err_d;
        end
    end

    frame_out_buffer #(.WIDTH(WIDTH)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .commit   (commit_q),
        .word     (shift_q),
        .ready    (ready),
        .data_out (data_out),
        .valid    (valid),
        .overrun  (overrun)
    );

    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: directed scoreboard bench for serial_frame_receiver (WIDTH=8, no parity).
module tb_serial_frame_receiver;
    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, in = 1'b1, direction = 1'b0, ready = 1'b1;
    logic [7:0] data_out;
    logic       valid, busy, frame_err, overrun;
    logic [7:0] q[$];
    int         tests = 0, fails = 0, fe_cnt = 0, ov_cnt = 0;

    serial_frame_receiver #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in        (in),
        .direction (direction),
        .ready     (ready),
        .data_out  (data_out),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: drive inputs, account for a handshake taken at this edge, then sample after it
    task automatic step(input logic e, input logic b);
        logic       acc;
        logic [7:0] w;
        en  = e;
        in  = b;
        acc = valid && ready;
        w   = data_out;
        @(posedge clk);
        #1;
        if (acc) begin
            tests++;
            assert (q.size() > 0) else begin
                fails++;
                $error("FAIL sb_underflow observed=%0h expected=none", w);
            end
            if (q.size() > 0) chk("sb_word", {24'd0, w}, {24'd0, q.pop_front()});
        end
        fe_cnt += int'(frame_err);
        ov_cnt += int'(overrun);
        chk("err_ovr_excl", {31'd0, frame_err & overrun}, 32'd0);
    endtask

    // start bit, 8 data bits in line order for dir, stop bit; direction flips after the start bit
    task automatic send(input logic [7:0] w, input logic d, input logic stop, input logic gap);
        logic b;
        direction = d;
        step(1'b1, 1'b0);
        if (gap) step(1'b0, 1'($urandom));
        direction = ~d;
        for (int i = 0; i < 8; i++) begin
            b = d ? w[i] : w[7-i];
            step(1'b1, b);
            if (gap) step(1'b0, ~b);
        end
        step(1'b1, stop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b1;
        idle(2);

        // 1: single frame latency, then back-to-back frames, MSB first
        ready = 1'b1;
        q.push_back(8'hA5);
        send(8'hA5, 1'b0, 1'b1, 1'b0);
        chk("t1_valid_lat", {31'd0, valid}, 32'd0);
        step(1'b1, 1'b1);
        chk("t1_valid", {31'd0, valid}, 32'd1);
        chk("t1_data", {24'd0, data_out}, 32'hA5);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        step(1'b1, 1'b1);
        chk("t1_valid_drop", {31'd0, valid}, 32'd0);
        q.push_back(8'h3C);
        q.push_back(8'h96);
        send(8'h3C, 1'b0, 1'b1, 1'b0);
        send(8'h96, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("t1_sb_empty", q.size(), 32'd0);

        // 2: LSB first, direction toggled mid-frame
        q.push_back(8'hA5);
        send(8'hA5, 1'b1, 1'b1, 1'b0);
        q.push_back(8'h3C);
        send(8'h3C, 1'b1, 1'b1, 1'b0);
        q.push_back(8'h1E);
        send(8'h1E, 1'b1, 1'b1, 1'b0);
        idle(3);
        chk("t2_sb_empty", q.size(), 32'd0);

        // 3: bad stop bit, line held low, then released
        fe_cnt = 0;
        send(8'h77, 1'b0, 1'b0, 1'b0);
        chk("t3_ferr", {31'd0, frame_err}, 32'd1);
        chk("t3_busy_stop", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            chk("t3_busy_break", {31'd0, busy}, 32'd1);
        end
        chk("t3_valid", {31'd0, valid}, 32'd0);
        step(1'b1, 1'b1);
        chk("t3_busy_idle", {31'd0, busy}, 32'd0);
        idle(2);
        chk("t3_ferr_once", fe_cnt, 32'd1);

        // 4: overrun with a stalled consumer, then a commit that coincides with acceptance
        ready  = 1'b0;
        ov_cnt = 0;
        q.push_back(8'h11);
        send(8'h11, 1'b0, 1'b1, 1'b0);
        send(8'h22, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("t4_ovr_pulse", {31'd0, overrun}, 32'd1);
        step(1'b1, 1'b1);
        chk("t4_ovr_clear", {31'd0, overrun}, 32'd0);
        chk("t4_data_held", {24'd0, data_out}, 32'h11);
        chk("t4_valid_held", {31'd0, valid}, 32'd1);
        q.push_back(8'h22);
        send(8'h22, 1'b0, 1'b1, 1'b0);
        ready = 1'b1;
        step(1'b1, 1'b1);
        chk("t4_data_new", {24'd0, data_out}, 32'h22);
        chk("t4_valid_new", {31'd0, valid}, 32'd1);
        idle(2);
        chk("t4_ovr_once", ov_cnt, 32'd1);
        chk("t4_sb_empty", q.size(), 32'd0);

        // 5: en strobing every other cycle with garbage on idle cycles
        q.push_back(8'h5A);
        send(8'h5A, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("t5_valid", {31'd0, valid}, 32'd1);
        chk("t5_data", {24'd0, data_out}, 32'h5A);
        idle(2);
        chk("t5_sb_empty", q.size(), 32'd0);

        // 6: asynchronous reset mid-frame, then a clean frame
        fe_cnt    = 0;
        direction = 1'b0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        chk("t6_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_valid", {31'd0, valid}, 32'd0);
        chk("t6_rst_data", {24'd0, data_out}, 32'd0);
        chk("t6_rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("t6_rst_ovr", {31'd0, overrun}, 32'd0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        rst = 1'b1;
        idle(2);
        q.push_back(8'hFF);
        send(8'hFF, 1'b0, 1'b1, 1'b0);
        ready = 1'b0;
        step(1'b1, 1'b1);
        chk("t6_valid", {31'd0, valid}, 32'd1);
        chk("t6_data", {24'd0, data_out}, 32'hFF);
        ready = 1'b1;
        idle(2);
        chk("t6_no_ferr", fe_cnt, 32'd0);
        chk("t6_sb_empty", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
